// File: rtl/uart_pkg.sv
// Shared types and frame timing helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  localparam int FRAME_BITS = 10;

  // Clock cycles one serial frame occupies on the line.
  function automatic int frame_cycles(input int tick_per_bit, input int frame_bits = FRAME_BITS);
    return tick_per_bit * frame_bits;
  endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational one-hot winner selection among pending requesters.
// UART_TX_ARB_RR_EN selects round-robin from ptr_i; otherwise lowest index wins.
module uart_arb_pick #(
  parameter int num_req = 3
) (
  input  logic [num_req-1:0]         req_i,
`ifdef UART_TX_ARB_RR_EN
  input  logic [$clog2(num_req)-1:0] ptr_i,
`endif
  output logic [num_req-1:0]         grant_o,
  output logic [$clog2(num_req)-1:0] idx_o
);

  localparam int IdxW = $clog2(num_req);

`ifdef UART_TX_ARB_RR_EN
  // Scan from farthest to nearest after the pointer so the nearest requester overwrites last.
  always_comb begin
    int cand;
    cand    = 0;
    grant_o = '0;
    idx_o   = '0;
    for (int off = num_req; off >= 1; off--) begin
      cand = (int'(ptr_i) + off) % num_req;
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = IdxW'(cand);
      end
    end
  end
`else
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int i = num_req - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IdxW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART Tx among several byte producers, timing out each frame since Tx has no busy flag.
// Define UART_TX_ARB_RR_EN for round-robin selection; default build is fixed priority.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int num_req      = 3,
  parameter int data_width   = 8,
  parameter int clk_freq     = 50000000,
  parameter int baudrate     = 9600,
  parameter int tick_per_bit = clk_freq / baudrate,
  parameter int frame_bits   = FRAME_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req,
  input  logic [num_req*data_width-1:0] req_data,
  output logic [num_req-1:0]            grant,
  output logic [$clog2(num_req)-1:0]    owner,
  output logic [data_width-1:0]         tx_data,
  output logic                          tx_send,
  output logic                          busy
);

  localparam int FRAME_CYC = frame_cycles(tick_per_bit, frame_bits);
  localparam int CNT_W     = $clog2(FRAME_CYC);
  localparam int IDX_W     = $clog2(num_req);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 2);

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [num_req-1:0]      grant_q;
  logic [IDX_W-1:0]        owner_q;
  logic [data_width-1:0]   tx_data_q;
  logic                    tx_send_q;
  logic                    busy_q;

  logic [num_req-1:0]      pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic [data_width-1:0]   pick_byte;

`ifdef UART_TX_ARB_RR_EN
  logic [IDX_W-1:0]        ptr_q;

  // Pointer starts at the top index so requester 0 has first priority out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDX_W'(num_req - 1);
    end else if (state_q == IDLE && |req) begin
      ptr_q <= pick_idx;
    end
  end
`endif

  uart_arb_pick #(
    .num_req(num_req)
  ) u_pick (
    .req_i  (req),
`ifdef UART_TX_ARB_RR_EN
    .ptr_i  (ptr_q),
`endif
    .grant_o(pick_grant),
    .idx_o  (pick_idx)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < num_req; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_byte = req_data[i*data_width +: data_width];
      end
    end
  end

  // Reset lands in WAIT so a frame Tx may still be shifting out completes before the next send.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT;
      cnt_q     <= '0;
      grant_q   <= '0;
      owner_q   <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q   <= SEND;
            grant_q   <= pick_grant;
            owner_q   <= pick_idx;
            tx_data_q <= pick_byte;
            tx_send_q <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
          end
        end
        SEND: begin
          state_q   <= WAIT;
          grant_q   <= '0;
          tx_send_q <= 1'b0;
          cnt_q     <= '0;
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
  assign busy    = busy_q;

endmodule
